// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over a req/ack
// IMEM port, holds it for the decoder and forms the next PC when the instruction retires.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic        instr_valid,
    input  logic        instr_done,
    input  logic [1:0]  PC_sel,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

    state_e         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    instr_q, instr_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [WdW-1:0] wd_q, wd_d;

    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic [31:0] next_pc;
    logic        unused_rs_low;

    assign seq_pc     = pc_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    // jr targets are word-aligned by construction; the dropped bits never raise an error
    assign unused_rs_low = ^rs_data[1:0];

    always_comb begin
        next_pc = seq_pc;
        unique case (PC_sel)
            2'b00: next_pc = seq_pc;
            2'b01: next_pc = zero ? (seq_pc + branch_off) : seq_pc;
            2'b10: next_pc = {seq_pc[31:28], instr_q[25:0], 2'b00};
            2'b11: next_pc = {rs_data[31:2], 2'b00};
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        wd_d    = wd_q;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                // ack takes priority over a watchdog expiry on the same edge
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = StIssue;
                end else if (wd_q == WdLast) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StIssue: begin
                if (instr_done) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    wd_d    = '0;
                    state_d = StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign func        = instr_q[5:0];
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against a transaction-level model of the fetch stage.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        instr_valid;
    logic        instr_done;
    logic [1:0]  pc_sel;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    pc_fetch_unit #(
        .RESET_PC      (RESET_PC),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .opcode     (opcode),
        .func       (func),
        .instr_valid(instr_valid),
        .instr_done (instr_done),
        .PC_sel     (pc_sel),
        .zero       (zero),
        .rs_data    (rs_data),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is either waiting one start-up cycle, fetching (counting misses),
    // holding an instruction until retired, or dead after a fetch error.
    bit          m_started;
    bit          m_holding;
    bit          m_err;
    int          m_misses;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ir,
                                               input logic [1:0] sel, input logic z,
                                               input logic [31:0] rs);
        logic [31:0] seq;
        int off;
        seq = p + 32'd4;
        off = int'($signed(ir[15:0])) * 4;
        case (sel)
            2'd0: return seq;
            2'd1: return z ? seq + 32'(off) : seq;
            2'd2: return (seq & 32'hF000_0000) | (32'(ir[25:0]) * 32'd4);
            default: return rs & ~32'd3;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_started <= 1'b0;
            m_holding <= 1'b0;
            m_err     <= 1'b0;
            m_misses  <= 0;
            m_pc      <= RESET_PC;
            m_instr   <= '0;
        end else if (!m_started) begin
            m_started <= 1'b1;
        end else if (m_err) begin
            m_err <= 1'b1;
        end else if (!m_holding) begin
            if (imem_ack) begin
                m_instr   <= imem_rdata;
                m_holding <= 1'b1;
            end else if (m_misses == TIMEOUT - 1) begin
                m_err <= 1'b1;
            end else begin
                m_misses <= m_misses + 1;
            end
        end else if (instr_done) begin
            m_pc      <= model_next(m_pc, m_instr, pc_sel, zero, rs_data);
            m_holding <= 1'b0;
            m_misses  <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic exp_req;
            exp_req = m_started && !m_holding && !m_err;
            chk("cyc imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("cyc imem_addr", imem_addr, m_pc);
            chk("cyc instr", instr, m_instr);
            chk("cyc opcode", 32'(opcode), 32'(m_instr[31:26]));
            chk("cyc func", 32'(func), 32'(m_instr[5:0]));
            chk("cyc instr_valid", 32'(instr_valid), 32'(m_holding));
            chk("cyc pc", pc, m_pc);
            chk("cyc pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("cyc fetch_err", 32'(fetch_err), 32'(m_err));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL wait_req: imem_req=%b expected 1 within 40 cycles", imem_req);
        end
    endtask

    task automatic fetch(input logic [31:0] w);
        wait_req();
        imem_ack   = 1'b1;
        imem_rdata = w;
        cyc();
        imem_ack = 1'b0;
    endtask

    task automatic retire(input logic [1:0] sel, input logic z, input logic [31:0] rs);
        instr_done = 1'b1;
        pc_sel     = sel;
        zero       = z;
        rs_data    = rs;
        cyc();
        instr_done = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        instr_done = 1'b0;
        pc_sel     = 2'd0;
        zero       = 1'b0;
        rs_data    = '0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        #1;
        chk("rst pc", pc, 32'h0000_3000);
        chk("rst imem_req", 32'(imem_req), 32'd0);
        chk("rst instr", instr, 32'd0);
        chk("rst fetch_err", 32'(fetch_err), 32'd0);
        rstn = 1'b1;

        // ori fetched with same-cycle ack, sequential retire
        wait_req();
        chk("t1 imem_addr", imem_addr, 32'h0000_3000);
        fetch(32'h3408_0005);
        chk("t1 instr_valid", 32'(instr_valid), 32'd1);
        chk("t1 opcode", 32'(opcode), 32'h0D);
        retire(2'b00, 1'b0, 32'd0);
        chk("t1 pc", pc, 32'h0000_3004);

        // jump and register jump
        fetch(32'h0000_0000);
        retire(2'b00, 1'b0, 32'd0);
        chk("t3 pc before j", pc, 32'h0000_3008);
        fetch(32'h0800_0C10);
        retire(2'b10, 1'b0, 32'd0);
        chk("t3 j pc", pc, 32'h0000_3040);
        fetch(32'h0000_0000);
        retire(2'b11, 1'b0, 32'h0000_3047);
        chk("t3 jr pc", pc, 32'h0000_3044);

        // beq with offset -1 word, taken and not taken
        fetch(32'h0000_0000);
        retire(2'b11, 1'b0, 32'h0000_3010);
        fetch(32'h1000_FFFF);
        retire(2'b01, 1'b1, 32'd0);
        chk("t2 beq taken", pc, 32'h0000_3010);
        fetch(32'h1000_FFFF);
        retire(2'b01, 1'b0, 32'd0);
        chk("t2 beq not taken", pc, 32'h0000_3014);

        // wrap at top of address space; instr_done during FETCH is ignored
        fetch(32'h0000_0000);
        retire(2'b11, 1'b0, 32'hFFFF_FFFF);
        chk("t6 pc top", pc, 32'hFFFF_FFFC);
        chk("t6 pc_plus4 wrap", pc_plus4, 32'h0000_0000);
        wait_req();
        instr_done = 1'b1;
        pc_sel     = 2'b00;
        cyc();
        cyc();
        chk("t6 no advance in fetch", pc, 32'hFFFF_FFFC);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0000;
        cyc();
        imem_ack = 1'b0;
        cyc();
        instr_done = 1'b0;
        chk("t6 wrapped pc", pc, 32'h0000_0000);

        // async reset mid-FETCH, ack during and just after reset ignored
        fetch(32'h0000_0000);
        retire(2'b11, 1'b0, 32'h0000_3020);
        wait_req();
        chk("t5 imem_addr", imem_addr, 32'h0000_3020);
        rstn = 1'b0;
        #1;
        chk("t5 req drops", 32'(imem_req), 32'd0);
        chk("t5 pc reset", pc, 32'h0000_3000);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cyc();
        rstn = 1'b1;
        cyc();
        imem_ack = 1'b0;
        chk("t5 req after reset", 32'(imem_req), 32'd1);
        chk("t5 late ack ignored", instr, 32'd0);

        // watchdog: ack on the last allowed cycle wins, then a full timeout
        repeat (TIMEOUT - 1) cyc();
        chk("t4 no err at limit", 32'(fetch_err), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        cyc();
        imem_ack = 1'b0;
        chk("t4 last-cycle ack", 32'(instr_valid), 32'd1);
        chk("t4 no err after ack", 32'(fetch_err), 32'd0);
        retire(2'b00, 1'b0, 32'd0);
        repeat (TIMEOUT - 1) cyc();
        chk("t4 err not yet", 32'(fetch_err), 32'd0);
        cyc();
        chk("t4 err set", 32'(fetch_err), 32'd1);
        chk("t4 req low in halt", 32'(imem_req), 32'd0);
        imem_ack = 1'b1;
        repeat (3) cyc();
        imem_ack = 1'b0;
        chk("t4 halt ignores ack", 32'(instr_valid), 32'd0);
        chk("t4 halt pc", pc, 32'h0000_3004);

        rstn = 1'b0;
        cyc();
        rstn = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rstn = 1'b0;
                cyc();
                rstn = 1'b1;
            end
            imem_ack   = ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
            instr_done = ($urandom_range(0, 9) < 4);
            pc_sel     = 2'($urandom_range(0, 3));
            zero       = ($urandom_range(0, 1) == 1);
            rs_data    = $urandom;
            cyc();
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
